// File: rtl/cpu_pipeline_pkg.sv
// Shared pipeline definitions: architectural width and per-barrier bundle layouts.
// Each barrier bundle packs its fields LSB-first at the listed offsets.
package cpu_pipeline_pkg;

  localparam int CPU_XLEN = 32;
  localparam int REG_IDX_W = 5;
  localparam int CTRL_W = 8;

  // IF/ID: {instr, pc}
  localparam int IF_ID_PC_LSB = 0;
  localparam int IF_ID_INSTR_LSB = IF_ID_PC_LSB + CPU_XLEN;
  localparam int IF_ID_W = IF_ID_INSTR_LSB + CPU_XLEN;

  // ID/EX: {ctrl, rd, imm, rs2Val, rs1Val, pc}
  localparam int ID_EX_PC_LSB = 0;
  localparam int ID_EX_RS1_LSB = ID_EX_PC_LSB + CPU_XLEN;
  localparam int ID_EX_RS2_LSB = ID_EX_RS1_LSB + CPU_XLEN;
  localparam int ID_EX_IMM_LSB = ID_EX_RS2_LSB + CPU_XLEN;
  localparam int ID_EX_RD_LSB = ID_EX_IMM_LSB + CPU_XLEN;
  localparam int ID_EX_CTRL_LSB = ID_EX_RD_LSB + REG_IDX_W;
  localparam int ID_EX_W = ID_EX_CTRL_LSB + CTRL_W;

  // EX/MEM: {ctrl, rd, rs2Val, aluResult}
  localparam int EX_MEM_ALU_LSB = 0;
  localparam int EX_MEM_RS2_LSB = EX_MEM_ALU_LSB + CPU_XLEN;
  localparam int EX_MEM_RD_LSB = EX_MEM_RS2_LSB + CPU_XLEN;
  localparam int EX_MEM_CTRL_LSB = EX_MEM_RD_LSB + REG_IDX_W;
  localparam int EX_MEM_W = EX_MEM_CTRL_LSB + CTRL_W;

  // MEM/WB: {ctrl, rd, wbData}
  localparam int MEM_WB_DATA_LSB = 0;
  localparam int MEM_WB_RD_LSB = MEM_WB_DATA_LSB + CPU_XLEN;
  localparam int MEM_WB_CTRL_LSB = MEM_WB_RD_LSB + REG_IDX_W;
  localparam int MEM_WB_W = MEM_WB_CTRL_LSB + CTRL_W;

endpackage

// File: rtl/skid_slot.sv
// One valid+data holding register. clear wins over load; drain drops valid
// but keeps the data bits so the held value stays stable until replaced.
module skid_slot #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] loadData,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= RESET_VALUE;
    end else if (clear) begin
      valid <= 1'b0;
      data  <= RESET_VALUE;
    end else if (load) begin
      valid <= 1'b1;
      data  <= loadData;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipeline_barrier_skid.sv
// Inter-stage barrier with valid/ready handshake, flush, 1-entry skid buffer
// and a saturating stall counter.
//
// Handshake: a bundle moves when valid and ready are both 1 at a rising clk
// edge; valid may not depend on ready, and inReady is a register output
// (~skidValid) so downstream back-pressure never reaches upstream combinationally.
module pipeline_barrier_skid
  import cpu_pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = CPU_XLEN,
  parameter int COUNTER_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     inValid,
  output logic                     inReady,
  input  logic [DATA_WIDTH-1:0]    inData,
  input  logic                     flush,
  output logic                     outValid,
  input  logic                     outReady,
  output logic [DATA_WIDTH-1:0]    outData,
  output logic [COUNTER_WIDTH-1:0] stallCount
);

  localparam logic [COUNTER_WIDTH-1:0] COUNT_MAX = '1;

  logic                  mainValid;
  logic [DATA_WIDTH-1:0] mainData;
  logic                  skidValid;
  logic [DATA_WIDTH-1:0] skidData;

  logic                  inXfer;
  logic                  mainFree;
  logic                  mainLoad;
  logic                  mainDrain;
  logic [DATA_WIDTH-1:0] mainLoadData;
  logic                  skidLoad;
  logic                  skidDrain;

  assign inReady  = ~skidValid;
  assign outValid = mainValid;
  assign outData  = mainData;

  always_comb begin
    inXfer       = inValid & inReady;
    // Main can take a new bundle this edge: it is empty or its bundle leaves.
    mainFree     = ~mainValid | outReady;
    // Skid has priority so older bundles always leave first.
    mainLoadData = skidValid ? skidData : inData;
    mainLoad     = ~flush & mainFree & (skidValid | inXfer);
    mainDrain    = ~flush & mainFree & ~skidValid & ~inXfer;
    skidLoad     = ~flush & ~mainFree & inXfer;
    skidDrain    = ~flush & mainFree & skidValid;
  end

  skid_slot #(
    .WIDTH       (DATA_WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) mainSlot (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (flush),
    .load     (mainLoad),
    .drain    (mainDrain),
    .loadData (mainLoadData),
    .valid    (mainValid),
    .data     (mainData)
  );

  skid_slot #(
    .WIDTH       (DATA_WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) skidSlot (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (flush),
    .load     (skidLoad),
    .drain    (skidDrain),
    .loadData (inData),
    .valid    (skidValid),
    .data     (skidData)
  );

  // Stall counter survives flush so it covers whole program runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCount <= '0;
    end else if (mainValid && !outReady && (stallCount != COUNT_MAX)) begin
      stallCount <= stallCount + 1'b1;
    end
  end

endmodule
